plugboard_swap_unit: RTL and testbench

- Consumer side of plugboard programming. Accepts a stream of one-hot letter strobes from the keyboard/switch front end, pairs them into swaps and validates each pair.
- Holds the resulting symmetric 26-letter map.
- Serves two registered lookup ports: forward (keyboard -> rotors, drives front_plug_out) and return (reflector -> lamps, drives rear_plug_out).
- Sits between the input front end, the rotor/reflector stack and the GUI in the enigma top level.

---
 rtl/enigma_pkg.sv | 30 +++
 rtl/plugboard_swap_unit_letter_encode.sv | 21 ++
 rtl/plugboard_swap_unit.sv | 164 ++++++++++++++++
 tb/tb_plugboard_swap_unit.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/enigma_pkg.sv
// enigma_pkg: shared types and constants for the plugboard programming path.
//   NUM_LETTERS    alphabet size (26)
//   letter_idx_t   5-bit letter index (A=0 .. Z=25)
//   letter_oh_t    26-bit one-hot letter (bit0=A .. bit25=Z)
//   ERR_*          rejection reason codes reported on err_code
//   plug_state_t   plugboard programming FSM states
// Optional feature macro: PLUG_UNPLUG_EN adds the UNPLUG state.
package enigma_pkg;

    localparam int unsigned NUM_LETTERS = 26;

    typedef logic [4:0]             letter_idx_t;
    typedef logic [NUM_LETTERS-1:0] letter_oh_t;

    localparam logic [1:0] ERR_BAD_LETTER = 2'd0;
    localparam logic [1:0] ERR_IN_USE     = 2'd1;
    localparam logic [1:0] ERR_SELF       = 2'd2;
    localparam logic [1:0] ERR_FULL       = 2'd3;

`ifdef PLUG_UNPLUG_EN
    typedef enum logic [1:0] {WAIT_A, WAIT_B, COMMIT, UNPLUG} plug_state_t;
`else
    typedef enum logic [1:0] {WAIT_A, WAIT_B, COMMIT} plug_state_t;
`endif

    function automatic letter_oh_t idx_to_oh(input letter_idx_t idx);
        return letter_oh_t'(1) << idx;
    endfunction

endpackage

// File: rtl/plugboard_swap_unit_letter_encode.sv
// letter_encode: combinational one-hot to index encoder.
//   oh         in  26  one-hot letter
//   idx        out 5   index of the set bit (meaningless unless is_onehot)
//   is_onehot  out 1   exactly one bit of oh is set
module letter_encode
    import enigma_pkg::*;
(
    input  logic [NUM_LETTERS-1:0] oh,
    output logic [4:0]             idx,
    output logic                   is_onehot
);

    always_comb begin
        idx = '0;
        for (int unsigned i = 0; i < NUM_LETTERS; i++) begin
            if (oh[i]) idx = idx | letter_idx_t'(i);
        end
        is_onehot = (oh != '0) && ((oh & (oh - 1'b1)) == '0);
    end

endmodule

// File: rtl/plugboard_swap_unit.sv
// plugboard_swap_unit: pairs programming strobes into plugboard swaps, keeps
// the symmetric 26-letter map and serves registered forward/return lookups.
//   CLOCK_50                    system clock, rising edge
//   reset                       asynchronous active-low reset
//   clear                       synchronous wipe of all pairs
//   prog_valid/prog_letter      one-hot letter strobe, prog_ready handshake
//   fwd_valid/fwd_in            forward lookup -> fwd_out/fwd_out_valid
//   rev_valid/rev_in            return lookup  -> rev_out/rev_out_valid
//   pair_count                  committed pairs
//   half_pending                first letter of a pair is held
//   err/err_code                rejected-strobe pulse and reason
// Optional feature macro: PLUG_UNPLUG_EN (strobing a plugged letter in
// WAIT_A removes its pair instead of reporting IN_USE).
module plugboard_swap_unit
    import enigma_pkg::*;
#(
    parameter int MAX_PAIRS = 10,
    parameter int PCW       = 4
) (
    input  logic                   CLOCK_50,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   prog_valid,
    input  logic [NUM_LETTERS-1:0] prog_letter,
    output logic                   prog_ready,
    input  logic                   fwd_valid,
    input  logic [NUM_LETTERS-1:0] fwd_in,
    output logic [NUM_LETTERS-1:0] fwd_out,
    output logic                   fwd_out_valid,
    input  logic                   rev_valid,
    input  logic [NUM_LETTERS-1:0] rev_in,
    output logic [NUM_LETTERS-1:0] rev_out,
    output logic                   rev_out_valid,
    output logic [PCW-1:0]         pair_count,
    output logic                   half_pending,
    output logic                   err,
    output logic [1:0]             err_code
);

    plug_state_t            state;
    letter_idx_t            map [NUM_LETTERS];
    logic [NUM_LETTERS-1:0] mask;
    letter_idx_t            a_idx;
    letter_idx_t            b_idx;

    letter_idx_t prog_idx, fwd_idx, rev_idx;
    logic        prog_oh, fwd_oh, rev_oh;
    logic        accept;

    letter_encode u_enc_prog (.oh(prog_letter), .idx(prog_idx), .is_onehot(prog_oh));
    letter_encode u_enc_fwd  (.oh(fwd_in),      .idx(fwd_idx),  .is_onehot(fwd_oh));
    letter_encode u_enc_rev  (.oh(rev_in),      .idx(rev_idx),  .is_onehot(rev_oh));

    assign accept = prog_valid && prog_ready;

    // prog_ready and half_pending are registered alongside every state
    // transition so they read 0 while reset is asserted and track the
    // state from the first clock afterwards.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state         <= WAIT_A;
            mask          <= '0;
            a_idx         <= '0;
            b_idx         <= '0;
            pair_count    <= '0;
            prog_ready    <= 1'b0;
            half_pending  <= 1'b0;
            err           <= 1'b0;
            err_code      <= '0;
            fwd_out       <= '0;
            fwd_out_valid <= 1'b0;
            rev_out       <= '0;
            rev_out_valid <= 1'b0;
            for (int unsigned i = 0; i < NUM_LETTERS; i++) map[i] <= letter_idx_t'(i);
        end else begin
            err        <= 1'b0;
            prog_ready <= 1'b1;

            // Lookups read the map as it stands before this edge's update.
            fwd_out_valid <= fwd_valid;
            rev_out_valid <= rev_valid;
            if (fwd_valid) fwd_out <= fwd_oh ? idx_to_oh(map[fwd_idx]) : fwd_in;
            if (rev_valid) rev_out <= rev_oh ? idx_to_oh(map[rev_idx]) : rev_in;

            if (clear) begin
                state        <= WAIT_A;
                half_pending <= 1'b0;
                mask         <= '0;
                pair_count   <= '0;
                for (int unsigned i = 0; i < NUM_LETTERS; i++) map[i] <= letter_idx_t'(i);
            end else begin
                case (state)
                    WAIT_A: begin
                        if (accept) begin
                            if (!prog_oh) begin
                                err      <= 1'b1;
                                err_code <= ERR_BAD_LETTER;
                            end else if (mask[prog_idx]) begin
`ifdef PLUG_UNPLUG_EN
                                a_idx      <= prog_idx;
                                err_code   <= '0;
                                state      <= UNPLUG;
                                prog_ready <= 1'b0;
`else
                                err      <= 1'b1;
                                err_code <= ERR_IN_USE;
`endif
                            end else if (pair_count == PCW'(MAX_PAIRS)) begin
                                err      <= 1'b1;
                                err_code <= ERR_FULL;
                            end else begin
                                a_idx        <= prog_idx;
                                err_code     <= '0;
                                state        <= WAIT_B;
                                half_pending <= 1'b1;
                            end
                        end
                    end
                    WAIT_B: begin
                        if (accept) begin
                            half_pending <= 1'b0;
                            state        <= WAIT_A;
                            if (!prog_oh) begin
                                err      <= 1'b1;
                                err_code <= ERR_BAD_LETTER;
                            end else if (mask[prog_idx]) begin
                                err      <= 1'b1;
                                err_code <= ERR_IN_USE;
                            end else if (prog_idx == a_idx) begin
                                err      <= 1'b1;
                                err_code <= ERR_SELF;
                            end else begin
                                b_idx      <= prog_idx;
                                err_code   <= '0;
                                state      <= COMMIT;
                                prog_ready <= 1'b0;
                            end
                        end
                    end
                    COMMIT: begin
                        map[a_idx]  <= b_idx;
                        map[b_idx]  <= a_idx;
                        mask[a_idx] <= 1'b1;
                        mask[b_idx] <= 1'b1;
                        pair_count  <= pair_count + 1'b1;
                        state       <= WAIT_A;
                    end
`ifdef PLUG_UNPLUG_EN
                    UNPLUG: begin
                        map[a_idx]        <= a_idx;
                        map[map[a_idx]]   <= map[a_idx];
                        mask[a_idx]       <= 1'b0;
                        mask[map[a_idx]]  <= 1'b0;
                        pair_count        <= pair_count - 1'b1;
                        state             <= WAIT_A;
                    end
`endif
                    default: state <= WAIT_A;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_plugboard_swap_unit.sv
module tb_plugboard_swap_unit;
    import enigma_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clear = 1'b0;
    logic        prog_valid = 1'b0;
    logic [25:0] prog_letter = '0;
    logic        prog_ready;
    logic        fwd_valid = 1'b0;
    logic [25:0] fwd_in = '0;
    logic [25:0] fwd_out;
    logic        fwd_out_valid;
    logic        rev_valid = 1'b0;
    logic [25:0] rev_in = '0;
    logic [25:0] rev_out;
    logic        rev_out_valid;
    logic [3:0]  pair_count;
    logic        half_pending;
    logic        err;
    logic [1:0]  err_code;

    int total = 0;
    int bad = 0;

    plugboard_swap_unit #(.MAX_PAIRS(10), .PCW(4)) dut (
        .CLOCK_50(clk), .reset(reset), .clear(clear),
        .prog_valid(prog_valid), .prog_letter(prog_letter), .prog_ready(prog_ready),
        .fwd_valid(fwd_valid), .fwd_in(fwd_in), .fwd_out(fwd_out), .fwd_out_valid(fwd_out_valid),
        .rev_valid(rev_valid), .rev_in(rev_in), .rev_out(rev_out), .rev_out_valid(rev_out_valid),
        .pair_count(pair_count), .half_pending(half_pending), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    localparam logic [25:0] LA = 26'd1;
    localparam logic [25:0] LB = 26'd1 << 1;
    localparam logic [25:0] LC = 26'd1 << 2;
    localparam logic [25:0] LH = 26'd1 << 7;
    localparam logic [25:0] LT = 26'd1 << 19;
    localparam logic [25:0] LZ = 26'd1 << 25;

    typedef struct {
        logic [25:0] letter;
        logic        exp_err;
        logic [1:0]  exp_code;
        logic        exp_half;
        logic        exp_ready;
        logic [3:0]  exp_count;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one strobe once prog_ready is seen; returns 1 ns after the accepting edge.
    task automatic strobe(input logic [25:0] l);
        int n = 0;
        @(negedge clk);
        while (!prog_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!prog_ready) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: got 0 expected 1");
        end
        prog_valid  = 1'b1;
        prog_letter = l;
        @(posedge clk);
        #1;
        prog_valid  = 1'b0;
        prog_letter = '0;
    endtask

    task automatic lookup(input string name, input logic [25:0] fi, input logic [25:0] ri,
                          input logic [25:0] ef, input logic [25:0] er);
        @(negedge clk);
        fwd_valid = 1'b1; fwd_in = fi;
        rev_valid = 1'b1; rev_in = ri;
        @(posedge clk);
        #1;
        fwd_valid = 1'b0; rev_valid = 1'b0;
        check({name, "_fwd"}, fwd_out, ef);
        check({name, "_fwd_valid"}, fwd_out_valid, 1);
        check({name, "_rev"}, rev_out, er);
        check({name, "_rev_valid"}, rev_out_valid, 1);
    endtask

    task automatic make_pair(input logic [25:0] x, input logic [25:0] y);
        strobe(x);
        strobe(y);
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            letter    err  code half ready count
        vecs[0] = '{LA,        1'b0, 2'd0, 1'b1, 1'b1, 4'd0};
        vecs[1] = '{LZ,        1'b0, 2'd0, 1'b0, 1'b0, 4'd1};
        vecs[2] = '{LB,        1'b0, 2'd0, 1'b1, 1'b1, 4'd1};
        vecs[3] = '{LB,        1'b1, 2'd2, 1'b0, 1'b1, 4'd1};
        vecs[4] = '{LA | LB,   1'b1, 2'd0, 1'b0, 1'b1, 4'd1};
        vecs[5] = '{26'd0,     1'b1, 2'd0, 1'b0, 1'b1, 4'd1};
        vecs[6] = '{LB,        1'b0, 2'd0, 1'b1, 1'b1, 4'd1};
        vecs[7] = '{LA,        1'b1, 2'd1, 1'b0, 1'b1, 4'd1};
        vecs[8] = '{LB,        1'b0, 2'd0, 1'b1, 1'b1, 4'd1};
        vecs[9] = '{LC,        1'b0, 2'd0, 1'b0, 1'b0, 4'd2};

        // Reset state
        #12;
        check("rst_ready", prog_ready, 0);
        check("rst_count", pair_count, 0);
        check("rst_half", half_pending, 0);
        check("rst_err", err, 0);
        check("rst_fwd_valid", fwd_out_valid, 0);
        check("rst_fwd_out", fwd_out, 0);
        @(negedge clk);
        reset = 1'b1;

        lookup("ident_h", LH, LH, LH, LH);
        check("ident_count", pair_count, 0);

        foreach (vecs[i]) begin
            strobe(vecs[i].letter);
            check($sformatf("v%0d_err", i), err, vecs[i].exp_err);
            if (vecs[i].exp_err) check($sformatf("v%0d_code", i), err_code, vecs[i].exp_code);
            check($sformatf("v%0d_half", i), half_pending, vecs[i].exp_half);
            check($sformatf("v%0d_ready", i), prog_ready, vecs[i].exp_ready);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_err_pulse", i), err, 0);
            check($sformatf("v%0d_count", i), pair_count, vecs[i].exp_count);
        end

        lookup("az", LA, LZ, LZ, LA);
        lookup("bc", LB, LC, LC, LB);
        lookup("h_id", LH, LT, LH, LT);
        lookup("zero", 26'd0, LA | LB, 26'd0, LA | LB);

        // Fill to 10 pairs: D/E .. R/S
        for (int k = 0; k < 8; k++) begin
            logic [25:0] x, y;
            x = 26'd1 << (3 + 2 * k);
            y = 26'd1 << (4 + 2 * k);
            make_pair(x, y);
        end
        check("full_count", pair_count, 10);
        lookup("rs", 26'd1 << 17, 26'd1 << 18, 26'd1 << 18, 26'd1 << 17);
        strobe(LT);
        check("full_err", err, 1);
        check("full_code", err_code, 3);
        check("full_half", half_pending, 0);
        @(posedge clk);
        #1;
        check("full_hold", pair_count, 10);

        // clear with lookup in the same cycle sees the old map
        @(negedge clk);
        clear = 1'b1; fwd_valid = 1'b1; fwd_in = LA; rev_valid = 1'b0;
        @(posedge clk);
        #1;
        clear = 1'b0; fwd_valid = 1'b0;
        check("clr_pre_fwd", fwd_out, LZ);
        check("clr_count", pair_count, 0);
        check("clr_err", err, 0);
        lookup("clr_ident", LA, LZ, LA, LZ);

        // clear while holding a half pair, coincident with a strobe
        strobe(LA);
        check("half_set", half_pending, 1);
        @(negedge clk);
        clear = 1'b1; prog_valid = 1'b1; prog_letter = LB;
        @(posedge clk);
        #1;
        clear = 1'b0; prog_valid = 1'b0; prog_letter = '0;
        check("clrb_half", half_pending, 0);
        check("clrb_err", err, 0);
        check("clrb_ready", prog_ready, 1);
        @(posedge clk);
        #1;
        check("clrb_count", pair_count, 0);
        strobe(LA);
        check("clrb_wait_a", half_pending, 1);

        // lookup during COMMIT sees the pre-commit map
        strobe(LZ);
        check("commit_ready", prog_ready, 0);
        fwd_valid = 1'b1; fwd_in = LA;
        @(posedge clk);
        #1;
        fwd_valid = 1'b0;
        check("commit_pre_fwd", fwd_out, LA);
        check("commit_count", pair_count, 1);
        lookup("commit_post", LA, LZ, LZ, LA);

        // clear coincident with COMMIT wins
        strobe(LB);
        strobe(LC);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        check("clr_commit_count", pair_count, 0);
        lookup("clr_commit_map", LB, LA, LB, LA);

        // reset during COMMIT
        strobe(LA);
        strobe(LZ);
        #2;
        reset = 1'b0;
        #1;
        check("rstc_count", pair_count, 0);
        check("rstc_ready", prog_ready, 0);
        check("rstc_fwd_valid", fwd_out_valid, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rstc_count2", pair_count, 0);
        lookup("rstc_map", LA, LZ, LA, LZ);

        // strobing a plugged letter in WAIT_A
        make_pair(LA, LZ);
        check("up_pair", pair_count, 1);
        strobe(LZ);
`ifdef PLUG_UNPLUG_EN
        check("up_err", err, 0);
        check("up_ready", prog_ready, 0);
        @(posedge clk);
        #1;
        check("up_count", pair_count, 0);
        lookup("up_map", LA, LZ, LA, LZ);
`else
        check("up_err", err, 1);
        check("up_code", err_code, 1);
        @(posedge clk);
        #1;
        check("up_count", pair_count, 1);
        lookup("up_map", LA, LZ, LZ, LA);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
